// File: rtl/systolic_matmul_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic matrix-multiply engine:
//   - state_e     : controller state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   - acc_width() : result element width, 2*W + clog2(K)
//   - run_steps() : number of feed steps in RUN, K+M+N-2
// No ports (package).
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Wide enough that K full-scale products can never overflow.
    function automatic int acc_width(input int w, input int k);
        return 2 * w + $clog2(k);
    endfunction

    // The last product reaches PE(M-1,N-1) on step K+M+N-3.
    function automatic int run_steps(input int m, input int k, input int n);
        return k + m + n - 2;
    endfunction

endpackage

// File: rtl/systolic_matmul_ctrl_if.sv
// -----------------------------------------------------------------------------
// systolic_matmul_ctrl_if
// Operand/result handshake bundle of the systolic matrix-multiply engine.
//   i_valid/o_ready/i_A/i_B : operand side (upstream operand buffer)
//   o_valid/i_ready/o_C     : result side (downstream result writer)
//   o_busy                  : engine is computing or holding a result
// Modports: slave (the engine), master (the producer/consumer side).
// -----------------------------------------------------------------------------
interface systolic_matmul_ctrl_if #(
    parameter int W = 32,
    parameter int M = 3,
    parameter int K = 3,
    parameter int N = 3
);
    import systolic_pkg::*;

    localparam int ACC_W = acc_width(W, K);

    logic                   i_valid;
    logic                   o_ready;
    logic [M*K*W-1:0]       i_A;
    logic [K*N*W-1:0]       i_B;
    logic                   o_valid;
    logic                   i_ready;
    logic [M*N*ACC_W-1:0]   o_C;
    logic                   o_busy;

    modport slave (
        input  i_valid, i_A, i_B, i_ready,
        output o_ready, o_valid, o_C, o_busy
    );

    modport master (
        output i_valid, i_A, i_B, i_ready,
        input  o_ready, o_valid, o_C, o_busy
    );

endinterface

// File: rtl/systolic_matmul_ctrl_pe.sv
// -----------------------------------------------------------------------------
// systolic_pe
// One output-stationary processing element: accumulates a*b and forwards
// a to the right neighbour and b to the neighbour below, one cycle later.
// Ports:
//   i_clk, i_rst (sync, active-high), i_en (freeze when low),
//   i_clr (zero accumulator and pass registers), i_a/i_b operands in,
//   o_a/o_b registered pass-through, o_acc accumulator.
// -----------------------------------------------------------------------------
module systolic_pe #(
    parameter int W     = 32,
    parameter int ACC_W = 66
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic [W-1:0]     o_a,
    output logic [W-1:0]     o_b,
    output logic [ACC_W-1:0] o_acc
);
    logic [2*W-1:0]   prod_s;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [ACC_W-1:0] acc_q;

    // Operands widened first so the full 2W-bit product is kept.
    assign prod_s = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};

    // Accumulate and forward operands on every enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q   <= {W{1'b0}};
            b_q   <= {W{1'b0}};
            acc_q <= {ACC_W{1'b0}};
        end else if (i_en) begin
            if (i_clr) begin
                a_q   <= {W{1'b0}};
                b_q   <= {W{1'b0}};
                acc_q <= {ACC_W{1'b0}};
            end else begin
                a_q   <= i_a;
                b_q   <= i_b;
                acc_q <= acc_q + ACC_W'(prod_s);
            end
        end
    end

    assign o_a   = a_q;
    assign o_b   = b_q;
    assign o_acc = acc_q;

endmodule

// File: rtl/systolic_matmul_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_matmul_ctrl
// Output-stationary M x N systolic array computing C = A*B (A: MxK, B: KxN,
// unsigned) with its own IDLE/RUN/DONE sequencer.
// Ports:
//   i_clk           : clock
//   i_rst           : synchronous active-high reset
//   i_en            : global enable, all state freezes when low
//   bus (slave)     : operand handshake (i_valid/o_ready/i_A/i_B),
//                     result handshake (o_valid/i_ready/o_C), o_busy
// Optional build macro SYSTOLIC_DEBUG_EN adds:
//   o_d_a00         : A pass register of PE(0,0)
//   o_d_step        : step counter
// -----------------------------------------------------------------------------
module systolic_matmul_ctrl
    import systolic_pkg::*;
#(
    parameter int W = 32,
    parameter int M = 3,
    parameter int K = 3,
    parameter int N = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
`ifdef SYSTOLIC_DEBUG_EN
    output logic [W-1:0]              o_d_a00,
    output logic [$clog2(K+M+N)-1:0]  o_d_step,
`endif
    systolic_matmul_ctrl_if.slave     bus
);
    localparam int ACC_W     = acc_width(W, K);
    localparam int STEP_W    = $clog2(K + M + N);
    localparam int LAST_STEP = run_steps(M, K, N) - 1;

    state_e               state_q;
    logic [STEP_W-1:0]    step_q;
    logic                 rdy_q;
    logic                 valid_q;
    logic                 busy_q;
    logic [M*K*W-1:0]     a_op_q;
    logic [K*N*W-1:0]     b_op_q;
    logic [M*N*ACC_W-1:0] c_q;

    logic                 accept_s;
    logic                 pe_en_s;
    logic [W-1:0]         a_in_s   [M];
    logic [W-1:0]         b_in_s   [N];
    logic [W-1:0]         a_pass_s [M][N];
    logic [W-1:0]         b_pass_s [M][N];
    logic [ACC_W-1:0]     acc_s    [M][N];
    logic [M*N*ACC_W-1:0] c_pack_s;

    // rdy_q is only ever set while idle, so it doubles as the IDLE qualifier.
    assign accept_s = rdy_q & i_en & bus.i_valid;
    // The array only moves while running, plus the accept edge that clears it.
    assign pe_en_s  = i_en & ((state_q == ST_RUN) | accept_s);

    // Operand skew: row r sees A[r][t-r], column c sees B[t-c][c], else zero.
    always_comb begin
        for (int r = 0; r < M; r++) begin
            a_in_s[r] = {W{1'b0}};
            if ((int'(step_q) >= r) && ((int'(step_q) - r) < K)) begin
                a_in_s[r] = a_op_q[(r*K + int'(step_q) - r)*W +: W];
            end else begin
                a_in_s[r] = {W{1'b0}};
            end
        end
        for (int c = 0; c < N; c++) begin
            b_in_s[c] = {W{1'b0}};
            if ((int'(step_q) >= c) && ((int'(step_q) - c) < K)) begin
                b_in_s[c] = b_op_q[((int'(step_q) - c)*N + c)*W +: W];
            end else begin
                b_in_s[c] = {W{1'b0}};
            end
        end
    end

    for (genvar r = 0; r < M; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [W-1:0] a_src_s;
            logic [W-1:0] b_src_s;

            if (c == 0) begin : g_a_edge
                assign a_src_s = a_in_s[r];
            end else begin : g_a_int
                assign a_src_s = a_pass_s[r][c-1];
            end

            if (r == 0) begin : g_b_edge
                assign b_src_s = b_in_s[c];
            end else begin : g_b_int
                assign b_src_s = b_pass_s[r-1][c];
            end

            systolic_pe #(
                .W     (W),
                .ACC_W (ACC_W)
            ) u_pe (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_en  (pe_en_s),
                .i_clr (accept_s),
                .i_a   (a_src_s),
                .i_b   (b_src_s),
                .o_a   (a_pass_s[r][c]),
                .o_b   (b_pass_s[r][c]),
                .o_acc (acc_s[r][c])
            );

            assign c_pack_s[(r*N + c)*ACC_W +: ACC_W] = acc_s[r][c];
        end
    end

    // Sequencer with registered handshake outputs and result register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            step_q  <= {STEP_W{1'b0}};
            rdy_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            a_op_q  <= {(M*K*W){1'b0}};
            b_op_q  <= {(K*N*W){1'b0}};
            c_q     <= {(M*N*ACC_W){1'b0}};
        end else if (i_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_valid && rdy_q) begin
                        a_op_q  <= bus.i_A;
                        b_op_q  <= bus.i_B;
                        step_q  <= {STEP_W{1'b0}};
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        rdy_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    step_q <= step_q + STEP_W'(1);
                    if (step_q == STEP_W'(LAST_STEP)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle snapshots the settled accumulators.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        c_q     <= c_pack_s;
                    end else if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready = rdy_q & i_en;
    assign bus.o_valid = valid_q;
    assign bus.o_C     = c_q;
    assign bus.o_busy  = busy_q;

`ifdef SYSTOLIC_DEBUG_EN
    assign o_d_a00  = a_pass_s[0][0];
    assign o_d_step = step_q;
`endif

endmodule

// File: tb/tb_systolic_matmul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_matmul_ctrl
// Self-checking bench: a 32-bit 3x3x3 engine and an 8-bit 2x4x3 engine are
// driven with directed and $urandom operands; results are compared against a
// plain triple-loop matrix product computed here.
// -----------------------------------------------------------------------------
module tb_systolic_matmul_ctrl;

    localparam int W0 = 32, M0 = 3, K0 = 3, N0 = 3;
    localparam int ACC0 = 2*W0 + $clog2(K0);
    localparam int AW0 = M0*K0*W0, BW0 = K0*N0*W0, CW0 = M0*N0*ACC0;
    localparam int LAT0 = K0 + M0 + N0 - 1;

    localparam int W1 = 8, M1 = 2, K1 = 4, N1 = 3;
    localparam int ACC1 = 2*W1 + $clog2(K1);
    localparam int AW1 = M1*K1*W1, BW1 = K1*N1*W1, CW1 = M1*N1*ACC1;

    logic clk;
    logic rst;
    logic en;
    int   checks;
    int   passed;

    systolic_matmul_ctrl_if #(.W(W0), .M(M0), .K(K0), .N(N0)) bus0();
    systolic_matmul_ctrl_if #(.W(W1), .M(M1), .K(K1), .N(N1)) bus1();

`ifdef SYSTOLIC_DEBUG_EN
    logic [W0-1:0]              d0_a00;
    logic [$clog2(K0+M0+N0)-1:0] d0_step;
    logic [W1-1:0]              d1_a00;
    logic [$clog2(K1+M1+N1)-1:0] d1_step;
`endif

    systolic_matmul_ctrl #(.W(W0), .M(M0), .K(K0), .N(N0)) dut0 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (en),
`ifdef SYSTOLIC_DEBUG_EN
        .o_d_a00  (d0_a00),
        .o_d_step (d0_step),
`endif
        .bus      (bus0)
    );

    systolic_matmul_ctrl #(.W(W1), .M(M1), .K(K1), .N(N1)) dut1 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (en),
`ifdef SYSTOLIC_DEBUG_EN
        .o_d_a00  (d1_a00),
        .o_d_step (d1_step),
`endif
        .bus      (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [CW0-1:0] ref0(input logic [AW0-1:0] a, input logic [BW0-1:0] b);
        logic [CW0-1:0]  c;
        logic [ACC0-1:0] s;
        c = '0;
        for (int r = 0; r < M0; r++) begin
            for (int cc = 0; cc < N0; cc++) begin
                s = '0;
                for (int k = 0; k < K0; k++) begin
                    s = s + ACC0'(a[(r*K0+k)*W0 +: W0]) * ACC0'(b[(k*N0+cc)*W0 +: W0]);
                end
                c[(r*N0+cc)*ACC0 +: ACC0] = s;
            end
        end
        return c;
    endfunction

    function automatic logic [CW1-1:0] ref1(input logic [AW1-1:0] a, input logic [BW1-1:0] b);
        logic [CW1-1:0]  c;
        logic [ACC1-1:0] s;
        c = '0;
        for (int r = 0; r < M1; r++) begin
            for (int cc = 0; cc < N1; cc++) begin
                s = '0;
                for (int k = 0; k < K1; k++) begin
                    s = s + ACC1'(a[(r*K1+k)*W1 +: W1]) * ACC1'(b[(k*N1+cc)*W1 +: W1]);
                end
                c[(r*N1+cc)*ACC1 +: ACC1] = s;
            end
        end
        return c;
    endfunction

    function automatic logic [AW0-1:0] rnd0();
        logic [AW0-1:0] v;
        for (int i = 0; i < AW0/32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [BW1-1:0] rnd1();
        logic [BW1-1:0] v;
        for (int i = 0; i < BW1/8; i++) v[i*8 +: 8] = 8'($urandom_range(255));
        return v;
    endfunction

    // Offers one operand pair to dut0 and waits for the result; stimulus only.
    // Edges with index in [stall_at, stall_at+stall_len) are run with i_en low.
    task automatic send0(input logic [AW0-1:0] a, input logic [BW0-1:0] b,
                         input int stall_at, input int stall_len, input bit noise,
                         output int lat, output logic [CW0-1:0] c,
                         output bit run_ok, output bit to);
        int waitc;
        to = 1'b0; run_ok = 1'b1; lat = 0; c = '0; waitc = 0;
        bus0.i_A = a; bus0.i_B = b; bus0.i_valid = 1'b1;
        while (bus0.o_ready !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        if (bus0.o_ready !== 1'b1) begin
            to = 1'b1;
            bus0.i_valid = 1'b0;
            return;
        end
        tick();
        bus0.i_valid = noise;
        while (bus0.o_valid !== 1'b1 && lat < 200) begin
            if (noise) begin
                bus0.i_A = rnd0();
                bus0.i_B = rnd0();
            end
            en = !(lat >= stall_at && lat < stall_at + stall_len);
            if (bus0.o_ready !== 1'b0 || bus0.o_busy !== 1'b1) run_ok = 1'b0;
            tick();
            lat++;
        end
        en = 1'b1;
        bus0.i_valid = 1'b0;
        if (bus0.o_valid !== 1'b1) to = 1'b1;
        c = bus0.o_C;
    endtask

    task automatic consume0();
        bus0.i_ready = 1'b1;
        tick();
        bus0.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        tick();
        tick();
        checks++; if (bus0.o_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus0.o_ready); else passed++;
        checks++; if (bus0.o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus0.o_valid); else passed++;
        checks++; if (bus0.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus0.o_busy); else passed++;
        checks++; if (bus0.o_C !== '0) $display("FAIL reset_C: got nonzero want 0"); else passed++;
        rst = 1'b0;
        tick();
        checks++; if (bus0.o_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", bus0.o_ready); else passed++;
    endtask

    task automatic test_all_ones();
        int lat; logic [CW0-1:0] c; bit ok; bit to;
        logic [ACC0-1:0] want;
        want = 66'h2_FFFF_FFFA_0000_0003;
        send0('1, '1, -1, 0, 1'b0, lat, c, ok, to);
        checks++; if (to) $display("FAIL ones_timeout: no result"); else passed++;
        checks++; if (lat !== LAT0) $display("FAIL ones_latency: got %0d want %0d", lat, LAT0); else passed++;
        checks++; if (!ok) $display("FAIL ones_run_flags: ready/busy wrong during run"); else passed++;
        for (int i = 0; i < M0*N0; i++) begin
            checks++;
            if (c[i*ACC0 +: ACC0] !== want) $display("FAIL ones_C%0d: got %h want %h", i, c[i*ACC0 +: ACC0], want);
            else passed++;
        end
        consume0();
        checks++; if (bus0.o_valid !== 1'b0) $display("FAIL ones_consume_valid: got %b want 0", bus0.o_valid); else passed++;
    endtask

    task automatic test_identity_b2b();
        int lat; logic [CW0-1:0] c; bit ok; bit to;
        logic [AW0-1:0] a; logic [BW0-1:0] b;
        for (int pass = 1; pass <= 2; pass++) begin
            a = '0;
            for (int r = 0; r < 3; r++) a[(r*K0+r)*W0 +: W0] = W0'(pass);
            for (int i = 0; i < K0*N0; i++) b[i*W0 +: W0] = W0'(i + 1);
            send0(a, b, -1, 0, 1'b0, lat, c, ok, to);
            checks++; if (to || lat !== LAT0) $display("FAIL ident%0d_latency: got %0d want %0d", pass, lat, LAT0); else passed++;
            for (int i = 0; i < M0*N0; i++) begin
                checks++;
                if (c[i*ACC0 +: ACC0] !== ACC0'(pass*(i+1)))
                    $display("FAIL ident%0d_C%0d: got %0d want %0d", pass, i, c[i*ACC0 +: ACC0], pass*(i+1));
                else passed++;
            end
            consume0();
            checks++; if (bus0.o_ready !== 1'b1) $display("FAIL ident%0d_ready_after_consume: got %b want 1", pass, bus0.o_ready); else passed++;
        end
    endtask

    task automatic test_random();
        int lat; logic [CW0-1:0] c, exp_c; bit ok; bit to;
        logic [AW0-1:0] a; logic [BW0-1:0] b;
        for (int n = 0; n < 4; n++) begin
            a = rnd0(); b = rnd0();
            exp_c = ref0(a, b);
            send0(a, b, -1, 0, 1'b1, lat, c, ok, to);
            checks++; if (to || lat !== LAT0) $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, LAT0); else passed++;
            checks++; if (!ok) $display("FAIL rand%0d_run_flags: ready/busy wrong during run", n); else passed++;
            checks++; if (c !== exp_c) $display("FAIL rand%0d_C: got %h want %h", n, c[ACC0-1:0], exp_c[ACC0-1:0]); else passed++;
            consume0();
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [CW0-1:0] c; bit ok; bit to;
        logic [AW0-1:0] a; logic [BW0-1:0] b;
        a = rnd0(); b = rnd0();
        send0(a, b, -1, 0, 1'b0, lat, c, ok, to);
        checks++; if (to || c !== ref0(a, b)) $display("FAIL bp_C: got %h want %h", c[ACC0-1:0], ref0(a, b) >> 0); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus0.o_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", i, bus0.o_valid); else passed++;
            checks++; if (bus0.o_C !== c) $display("FAIL bp_stable%0d: C changed", i); else passed++;
            checks++; if (bus0.o_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", i, bus0.o_ready); else passed++;
        end
        consume0();
        checks++; if (bus0.o_valid !== 1'b0) $display("FAIL bp_consume_valid: got %b want 0", bus0.o_valid); else passed++;
    endtask

    task automatic test_stall();
        int lat; logic [CW0-1:0] c; bit ok; bit to;
        logic [AW0-1:0] a; logic [BW0-1:0] b;
        a = rnd0(); b = rnd0();
        send0(a, b, 3, 4, 1'b0, lat, c, ok, to);
        checks++; if (to || lat !== LAT0 + 4) $display("FAIL stall_latency: got %0d want %0d", lat, LAT0 + 4); else passed++;
        checks++; if (c !== ref0(a, b)) $display("FAIL stall_C: got %h", c[ACC0-1:0]); else passed++;
        consume0();
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [CW0-1:0] c; bit ok; bit to; bit seen;
        logic [AW0-1:0] a; logic [BW0-1:0] b;
        int waitc;
        bus0.i_A = rnd0(); bus0.i_B = rnd0(); bus0.i_valid = 1'b1;
        waitc = 0;
        while (bus0.o_ready !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        checks++; if (bus0.o_ready !== 1'b1) $display("FAIL rst_mid_accept: ready got %b want 1", bus0.o_ready); else passed++;
        tick();
        bus0.i_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus0.o_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", bus0.o_valid); else passed++;
        checks++; if (bus0.o_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bus0.o_busy); else passed++;
        checks++; if (bus0.o_ready !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", bus0.o_ready); else passed++;
        checks++; if (bus0.o_C !== '0) $display("FAIL rst_mid_C: got nonzero want 0"); else passed++;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus0.o_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) $display("FAIL rst_mid_no_pulse: got valid pulse want none"); else passed++;
        a = '0;
        for (int r = 0; r < 3; r++) a[(r*K0+r)*W0 +: W0] = 32'd1;
        for (int i = 0; i < K0*N0; i++) b[i*W0 +: W0] = W0'(i + 1);
        send0(a, b, -1, 0, 1'b0, lat, c, ok, to);
        checks++; if (to || lat !== LAT0) $display("FAIL rst_mid_fresh_latency: got %0d want %0d", lat, LAT0); else passed++;
        for (int i = 0; i < M0*N0; i++) begin
            checks++;
            if (c[i*ACC0 +: ACC0] !== ACC0'(i+1)) $display("FAIL rst_mid_fresh_C%0d: got %0d want %0d", i, c[i*ACC0 +: ACC0], i+1);
            else passed++;
        end
        consume0();
    endtask

    task automatic test_rect();
        int exp_rect [6];
        logic [AW1-1:0] a; logic [BW1-1:0] b; logic [BW1-1:0] r;
        logic [CW1-1:0] exp_c;
        int lat; int waitc;
        exp_rect = '{70, 80, 90, 158, 184, 210};
        for (int n = 0; n < 3; n++) begin
            if (n == 0) begin
                for (int i = 0; i < M1*K1; i++) a[i*W1 +: W1] = W1'(i + 1);
                for (int i = 0; i < K1*N1; i++) b[i*W1 +: W1] = W1'(i + 1);
                for (int i = 0; i < M1*N1; i++) exp_c[i*ACC1 +: ACC1] = ACC1'(exp_rect[i]);
            end else begin
                r = rnd1(); a = r[AW1-1:0];
                b = rnd1();
                if (n == 2) begin
                    a = '1;
                    b = '1;
                end
                exp_c = ref1(a, b);
            end
            bus1.i_A = a; bus1.i_B = b; bus1.i_valid = 1'b1;
            waitc = 0;
            while (bus1.o_ready !== 1'b1 && waitc < 20) begin
                tick();
                waitc++;
            end
            tick();
            bus1.i_valid = 1'b0;
            lat = 0;
            while (bus1.o_valid !== 1'b1 && lat < 200) begin
                tick();
                lat++;
            end
            checks++; if (lat !== 8) $display("FAIL rect%0d_latency: got %0d want 8", n, lat); else passed++;
            for (int i = 0; i < M1*N1; i++) begin
                checks++;
                if (bus1.o_C[i*ACC1 +: ACC1] !== exp_c[i*ACC1 +: ACC1])
                    $display("FAIL rect%0d_C%0d: got %0d want %0d", n, i, bus1.o_C[i*ACC1 +: ACC1], exp_c[i*ACC1 +: ACC1]);
                else passed++;
            end
            bus1.i_ready = 1'b1;
            tick();
            bus1.i_ready = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b1;
        en  = 1'b1;
        bus0.i_valid = 1'b0; bus0.i_ready = 1'b0; bus0.i_A = '0; bus0.i_B = '0;
        bus1.i_valid = 1'b0; bus1.i_ready = 1'b0; bus1.i_A = '0; bus1.i_B = '0;
        @(negedge clk);
        test_reset();
        test_all_ones();
        test_identity_b2b();
        test_random();
        test_backpressure();
        test_stall();
        test_reset_mid_run();
        test_rect();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/systolic_matmul_ctrl.md
# systolic_matmul_ctrl

Parametrised output-stationary systolic matrix-multiply engine with its own sequencing controller. It computes C = A·B for an M×K by K×N unsigned operand pair. It is the next-generation replacement for the fixed square N×N `control` unit: it supports rectangular dimensions, valid/ready handshakes on both sides, a global stall, and a width-safe accumulator. It sits between the operand buffer (upstream) and the result writer (downstream).

## Interface
- `W`, 32: element width in bits (unsigned).
- `M`, 3: rows of A and of C.
- `K`, 3: columns of A, rows of B (the reduction length).
- `N`, 3: columns of B and of C.
- `ACC_W`, derived as 2*W + $clog2(K) (equals 2*W when K=1): width of each result element. It is a localparam, not overridable.

Ports:
- `i_clk`, in, 1: the single clock. All logic is on its rising edge.
- `i_rst`, in, 1: reset. It is synchronous and active-high.
- `i_en`, in, 1: global enable. When low, all state freezes.
- `i_valid`, in, 1: the operand pair on `i_A` and `i_B` is valid.
- `o_ready`, out, 1: the block accepts operands this cycle.
- `i_A`, in, M*K*W: element A[r][c] is at bits [(r*K+c)*W +: W].
- `i_B`, in, K*N*W: element B[r][c] is at bits [(r*N+c)*W +: W].
- `o_valid`, out, 1: `o_C` holds a complete result.
- `i_ready`, in, 1: downstream consumes the result.
- `o_C`, out, M*N*ACC_W: element C[r][c] is at bits [(r*N+c)*ACC_W +: ACC_W].
- `o_busy`, out, 1: high in RUN and in DONE.

## Operation
The FSM has three states: IDLE, RUN and DONE.

- **IDLE**
  - `o_ready` = `i_en`.
  - On an edge where `i_valid`, `o_ready` and `i_en` are all high, the block:
    - captures `i_A` and `i_B` into operand registers,
    - clears all accumulators and inter-PE registers,
    - sets the step counter to 0,
    - moves to RUN.
- **RUN**
  - Each enabled cycle feeds step t, then increments t.
  - Row r of the array receives A[r][t−r] when 0 ≤ t−r < K, otherwise 0.
  - Column c receives B[t−c][c] when 0 ≤ t−c < K, otherwise 0.
  - Each PE(r,c) does three things per enabled cycle:
    - acc += a·b, with the full 2W-bit product zero-extended to ACC_W,
    - passes a to the right,
    - passes b downward.
  - The state moves to DONE after the enabled cycle in which t = K+M+N−3.
- **DONE**
  - `o_valid` = 1 and `o_C` = the accumulators.
  - `o_C` stays stable until an edge where `i_ready` and `i_en` are both high. The block then returns to IDLE.
  - Calculation overlap is not permitted: `o_ready` = 0 for the entire time in DONE.
- **Arithmetic**: all arithmetic is unsigned. Overflow cannot occur, because K·(2^W−1)² < 2^ACC_W.

## Timing
- **Reset values**: `o_ready` = 0, `o_valid` = 0, `o_busy` = 0, `o_C` = 0. The state is IDLE.
  - `o_ready` rises on the first cycle after reset deasserts, provided `i_en` = 1.
- **Latency**: `o_valid` rises on the (K+M+N−1)th enabled edge after the accepting edge.
  - For 3×3×3 this is 8 enabled cycles.
- **Throughput**: accepts recur at least every K+M+N enabled cycles when `i_ready` is held high.
- **`i_en` = 0**:
  - FSM, counter, PE and output registers all hold their values.
  - No handshake completes on either side.
  - Latency stretches by exactly the number of stalled cycles.
- **Reset mid-RUN or mid-DONE**: the current calculation is discarded with no `o_valid` pulse. All outputs return to their reset values on the next edge.
- **`i_valid` while `o_ready` = 0**: ignored. The operands are not sampled.
- **Simultaneous `i_rst` and a handshake**: reset wins.
- **Degenerate dimensions**: M = K = N = 1 is legal. The latency is then 2 enabled cycles.

## Configuration
- `SYSTOLIC_DEBUG_EN` defined: the block adds two output ports.
  - `o_d_a00`, W bits: the A input register of PE(0,0).
  - `o_d_step`, $clog2(K+M+N) bits: the step counter.
  - Both read 0 in reset.
- `SYSTOLIC_DEBUG_EN` undefined: those ports and their logic do not exist. All other behaviour is identical.

## Structure
- Package `systolic_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`),
  - the function `acc_width(W, K)`,
  - the function `run_steps(M, K, N)`, which returns K+M+N−2.
- Sub-module `systolic_pe` is instantiated M×N times in a generate loop.
  - Parameters: `W` and `ACC_W`.
  - Ports: `i_clk`, `i_rst`, `i_en`, `i_clr`, `i_a`, `i_b`, `o_a`, `o_b`, `o_acc`.
- The controller, the operand skew muxes and the output packing live in the top level.

## Test plan
- **All-ones, W=32, 3×3×3, every element 0xFFFFFFFF**: every C element = 0x2_FFFFFFFA_00000003 (ACC_W = 66), with `o_valid` 8 enabled cycles after accept.
- **Identity**: A = I₃, B = 1..9 row-major → `o_C` equals B exactly. A second back-to-back transaction with A = 2·I₃ gives 2..18.
- **Rectangular, W=8, M=2, K=4, N=3**: A = 1..8, B = 1..12 → C row 0 = 70 80 90, row 1 = 158 184 210, with latency 8.
- **Backpressure**: hold `i_ready` = 0 for 5 cycles in DONE → `o_valid` stays 1, `o_C` stays bit-stable, and `o_ready` stays 0 until the consuming edge.
- **Stall**: drop `i_en` for 4 cycles mid-RUN → the result is unchanged and `o_valid` rises exactly 4 cycles later than nominal.
- **Reset mid-RUN at step 3**: outputs go to 0 on the next edge with no `o_valid`. A fresh identity transaction afterwards returns the correct result.
